alu_multibyte_seq: RTL

- Sequencer that runs the existing 8-bit combinational ALU over NBYTES-wide operands, one byte per clock.
- Drives the ALU ports (OP, INPUTA/B/C, SC_IN, PC gate), chains carry through a register, and collects result bytes and flags.
- Sits beside the register file and serves multi-byte add, subtract, shift, add-immediate and compare requests from the control unit through a start/done handshake.

---
 rtl/alu_multibyte_seq_pkg.sv | 29 ++
 rtl/alu_multibyte_seq_alu.sv | 64 ++++++
 rtl/alu_multibyte_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_multibyte_seq_pkg.sv
// Shared op codes, sequencer states and ALU program-counter gate values
// for the multi-byte ALU sequencer.
package alu_multibyte_seq_pkg;

   typedef enum logic [3:0] {
      kADD  = 4'd0,
      kSUB  = 4'd1,
      kLSH  = 4'd2,
      kLSHC = 4'd3,
      kADDi = 4'd4,
      kcmp  = 4'd5
   } op_mne_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam logic [12:0] ALU_PC_RUN  = 13'd1;
   localparam logic [12:0] ALU_PC_IDLE = 13'd0;

   // kLSHC is an ALU-internal op; the sequencer only accepts whole-word ops
   function automatic logic op_legal(input logic [3:0] op);
      return (op == kADD) || (op == kSUB) || (op == kLSH) ||
             (op == kADDi) || (op == kcmp);
   endfunction

endpackage

// File: rtl/alu_multibyte_seq_alu.sv
// 8-bit combinational ALU; outputs are forced to zero while PC is 0 so the
// block idles whenever the sequencer is not running.
module alu_multibyte_seq_alu (
   input  logic [3:0]  OP,
   input  logic [7:0]  INPUTA,
   input  logic [7:0]  INPUTB,
   input  logic [4:0]  INPUTC,
   input  logic        SC_IN,
   input  logic [12:0] PC,
   output logic [7:0]  OUT,
   output logic        SC_OUT,
   output logic        BEQ,
   output logic        BGT
);
   import alu_multibyte_seq_pkg::*;

   logic [8:0] sum;
   logic       cin;

   always_comb begin
      OUT    = '0;
      SC_OUT = 1'b0;
      BEQ    = 1'b0;
      BGT    = 1'b0;
      sum    = '0;
      cin    = 1'b0;
      if (PC != 13'd0) begin
         case (OP)
            kADD: begin
               cin    = INPUTC[0] ? SC_IN : 1'b0;
               sum    = {1'b0, INPUTA} + {1'b0, INPUTB} + {8'd0, cin};
               OUT    = sum[7:0];
               SC_OUT = sum[8];
            end
            kSUB: begin
               // default carry of 1 makes A + ~B + 1 a plain subtract
               cin    = INPUTC[0] ? SC_IN : 1'b1;
               sum    = {1'b0, INPUTA} + {1'b0, ~INPUTB} + {8'd0, cin};
               OUT    = sum[7:0];
               SC_OUT = sum[8];
            end
            kLSH: begin
               OUT    = {INPUTA[6:0], 1'b0};
               SC_OUT = INPUTA[7];
            end
            kLSHC: begin
               OUT    = {INPUTA[6:0], SC_IN};
               SC_OUT = INPUTA[7];
            end
            kADDi: begin
               sum    = {1'b0, INPUTA} + {4'd0, INPUTC};
               OUT    = sum[7:0];
               SC_OUT = sum[8];
            end
            kcmp: begin
               BEQ = (INPUTA == INPUTB);
               BGT = (INPUTA > INPUTB);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_multibyte_seq.sv
// Runs the 8-bit ALU over NBYTES-wide operands one byte per clock, chaining
// carry through a register; compare walks MS byte first with early exit.
module alu_multibyte_seq #(
   parameter int NBYTES = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic [3:0]          OP,
   input  logic [8*NBYTES-1:0] A,
   input  logic [8*NBYTES-1:0] B,
   input  logic [4:0]          IMM,
   input  logic                USE_CIN,
   input  logic                CIN,
   output logic                BUSY,
   output logic                DONE,
   output logic [8*NBYTES-1:0] RESULT,
   output logic                COUT,
   output logic                EQ,
   output logic                GT,
   output logic                ERR
);
   import alu_multibyte_seq_pkg::*;

   localparam int W     = 8 * NBYTES;
   localparam int IDX_W = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

   seq_state_t       state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_q, b_q, res_nxt;
   logic [3:0]       op_q;
   logic [4:0]       imm_q;
   logic             use_cin_q, cin_q;
   logic             start_acc, first, finish;

   logic [3:0]       alu_op;
   logic [7:0]       alu_a, alu_b, alu_out;
   logic [4:0]       alu_c;
   logic             alu_sc_in, alu_sc_out, alu_beq, alu_bgt;
   logic [12:0]      alu_pc;

   assign start_acc = START && (state != RUN);
   assign first     = (idx == '0);
   assign finish    = (op_q == kcmp) ? (!alu_beq || first) : (idx == LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (START) state_nxt = op_legal(OP) ? RUN : alu_multibyte_seq_pkg::DONE;
         RUN:
            if (finish) state_nxt = alu_multibyte_seq_pkg::DONE;
         alu_multibyte_seq_pkg::DONE:
            if (START) state_nxt = op_legal(OP) ? RUN : alu_multibyte_seq_pkg::DONE;
            else       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      BUSY   = (state == RUN);
      DONE   = (state == alu_multibyte_seq_pkg::DONE);
      alu_pc = (state == RUN) ? ALU_PC_RUN : ALU_PC_IDLE;
   end

   // per-op steering of the ALU ports for the current byte
   always_comb begin
      alu_op    = op_q;
      alu_a     = a_q[8*idx +: 8];
      alu_b     = b_q[8*idx +: 8];
      alu_c     = 5'd1;
      alu_sc_in = first ? cin_q : carry;
      case (op_q)
         kADD, kSUB:
            if (first) alu_c = {4'd0, use_cin_q};
         kLSH: begin
            alu_b  = 8'd0;
            alu_op = (first && !use_cin_q) ? kLSH : kLSHC;
         end
         kADDi: begin
            alu_b = 8'd0;
            if (first) begin
               alu_op = kADDi;
               alu_c  = imm_q;
            end else begin
               alu_op = kADD;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      res_nxt = RESULT;
      res_nxt[8*idx +: 8] = alu_out;
   end

   alu_multibyte_seq_alu u_alu (
      .OP     (alu_op),
      .INPUTA (alu_a),
      .INPUTB (alu_b),
      .INPUTC (alu_c),
      .SC_IN  (alu_sc_in),
      .PC     (alu_pc),
      .OUT    (alu_out),
      .SC_OUT (alu_sc_out),
      .BEQ    (alu_beq),
      .BGT    (alu_bgt)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= kADD;
         imm_q     <= '0;
         use_cin_q <= 1'b0;
         cin_q     <= 1'b0;
         RESULT    <= '0;
         COUT      <= 1'b0;
         EQ        <= 1'b0;
         GT        <= 1'b0;
         ERR       <= 1'b0;
      end else if (start_acc) begin
         a_q       <= A;
         b_q       <= B;
         op_q      <= OP;
         imm_q     <= IMM;
         use_cin_q <= USE_CIN;
         cin_q     <= CIN;
         idx       <= (OP == kcmp) ? LAST : '0;
         carry     <= 1'b0;
         RESULT    <= '0;
         COUT      <= 1'b0;
         EQ        <= 1'b0;
         GT        <= 1'b0;
         ERR       <= !op_legal(OP);
      end else if (state == RUN) begin
         if (op_q == kcmp) begin
            if (!alu_beq) begin
               GT <= alu_bgt;
               EQ <= 1'b0;
            end else if (first) begin
               EQ <= 1'b1;
               GT <= 1'b0;
            end else begin
               idx <= idx - 1'b1;
            end
         end else begin
            RESULT <= res_nxt;
            carry  <= alu_sc_out;
            if (idx == LAST) begin
               COUT <= alu_sc_out;
               EQ   <= (res_nxt == '0);
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule
